// File: rtl/score_display_scheduler_if.sv
// Purpose: popup handshake plus display outputs shared by the scheduler and its consumers.
// Latency: wires only, no storage.
// Backpressure: popup_req is a level held until popup_ack; display outputs are never stalled.
interface score_display_scheduler_if;
  logic        popup_req;
  logic [20:0] popup_val;
  logic        popup_ack;
  logic        popup_active;
  logic [2:0]  page;
  logic [20:0] value;
  logic [2:0]  scan;
  logic [7:0]  seg_en;

  // Requester / display consumer side
  modport master (
    output popup_req, popup_val,
    input  popup_ack, popup_active, page, value, scan, seg_en
  );

  // Scheduler side
  modport slave (
    input  popup_req, popup_val,
    output popup_ack, popup_active, page, value, scan, seg_en
  );
endinterface

// File: rtl/score_display_scheduler.sv
// Purpose: rotates seven statistic pages on the 8-digit display, drives digit scan, grants timed popups.
// Latency: all outputs registered; a source or page change shows one cycle later, popup shows 1 cycle after acceptance.
// Backpressure: popup_req is held by the requester until a one-cycle popup_ack; requests in IDLE are ignored.
module score_display_scheduler #(
  parameter int TICK_DIV   = 200000,
  parameter int PAGE_TICKS = 500,
  parameter int POP_TICKS  = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        freeze,
  input  logic [20:0] combo,
  input  logic [20:0] base_score,
  input  logic [20:0] bonus_score,
  input  logic [20:0] acc,
  input  logic [1:0]  mod,
  input  logic [3:0]  difficulty,
  input  logic [2:0]  level,
  score_display_scheduler_if.slave dsp
);

  localparam int TW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
  localparam int PW = (PAGE_TICKS > 1) ? $clog2(PAGE_TICKS) : 1;
  localparam int OW = (POP_TICKS  > 1) ? $clog2(POP_TICKS)  : 1;

  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PAGE_MAX = PW'(PAGE_TICKS - 1);
  localparam logic [OW-1:0] POP_MAX  = OW'(POP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, ROTATE, POPUP} state_t;

  state_t        state_q,    state_n;
  logic [TW-1:0] tick_cnt_q, tick_cnt_n;
  logic [2:0]    scan_q,     scan_n;
  logic [PW-1:0] page_cnt_q, page_cnt_n;
  logic [OW-1:0] pop_cnt_q,  pop_cnt_n;
  // Rotation page; kept untouched during a popup so it doubles as the saved page.
  logic [2:0]    cur_page_q, cur_page_n;
  logic [20:0]   pop_val_q,  pop_val_n;
  logic          ack_q,      ack_n;
  logic [2:0]    page_q,     page_n;
  logic [20:0]   value_q,    value_n;
  logic [7:0]    seg_en_q,   seg_en_n;

  logic tick;
  logic accept;

  // Next-state, counters and registered display outputs
  always_comb begin
    state_n    = state_q;
    tick_cnt_n = tick_cnt_q;
    scan_n     = scan_q;
    page_cnt_n = page_cnt_q;
    pop_cnt_n  = pop_cnt_q;
    cur_page_n = cur_page_q;
    pop_val_n  = pop_val_q;
    ack_n      = 1'b0;
    page_n     = page_q;
    value_n    = value_q;
    seg_en_n   = seg_en_q;

    tick   = (state_q != IDLE) && (tick_cnt_q == TICK_MAX);
    // A request still high on the ack cycle is not taken again.
    accept = (state_q != IDLE) && dsp.popup_req && !ack_q;

    if (state_q != IDLE) begin
      tick_cnt_n = tick ? '0 : tick_cnt_q + 1'b1;
      if (tick) scan_n = scan_q + 3'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (en) state_n = ROTATE;
      end
      ROTATE: begin
        if (accept) begin
          // Acceptance swallows any page advance due this cycle.
          ack_n     = 1'b1;
          pop_val_n = dsp.popup_val;
          pop_cnt_n = '0;
          state_n   = POPUP;
        end else if (tick && !freeze) begin
          if (page_cnt_q == PAGE_MAX) begin
            page_cnt_n = '0;
            cur_page_n = (cur_page_q == 3'd6) ? 3'd0 : cur_page_q + 3'd1;
          end else begin
            page_cnt_n = page_cnt_q + 1'b1;
          end
        end
      end
      POPUP: begin
        if (accept) begin
          // Retrigger restarts the hold, even on the expiry tick.
          ack_n     = 1'b1;
          pop_val_n = dsp.popup_val;
          pop_cnt_n = '0;
        end else if (tick) begin
          if (pop_cnt_q == POP_MAX) begin
            state_n    = ROTATE;
            page_cnt_n = '0;
            pop_cnt_n  = '0;
          end else begin
            pop_cnt_n = pop_cnt_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Disable drops everything, including a latched popup.
    if (!en) begin
      state_n    = IDLE;
      tick_cnt_n = '0;
      scan_n     = '0;
      page_cnt_n = '0;
      pop_cnt_n  = '0;
      cur_page_n = '0;
      pop_val_n  = '0;
      ack_n      = 1'b0;
    end

    page_n = (state_n == POPUP) ? 3'd7 : cur_page_n;

    if (state_n == IDLE) begin
      value_n  = '0;
      seg_en_n = '0;
    end else begin
      seg_en_n = 8'(1) << scan_n;
      if (state_n == POPUP) begin
        value_n = pop_val_n;
      end else begin
        unique case (cur_page_n)
          3'd0:    value_n = combo;
          3'd1:    value_n = base_score;
          3'd2:    value_n = bonus_score;
          3'd3:    value_n = acc;
          3'd4:    value_n = {19'd0, mod};
          3'd5:    value_n = {17'd0, difficulty};
          3'd6:    value_n = {18'd0, level};
          default: value_n = '0;
        endcase
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      scan_q     <= '0;
      page_cnt_q <= '0;
      pop_cnt_q  <= '0;
      cur_page_q <= '0;
      pop_val_q  <= '0;
      ack_q      <= 1'b0;
      page_q     <= '0;
      value_q    <= '0;
      seg_en_q   <= '0;
    end else begin
      state_q    <= state_n;
      tick_cnt_q <= tick_cnt_n;
      scan_q     <= scan_n;
      page_cnt_q <= page_cnt_n;
      pop_cnt_q  <= pop_cnt_n;
      cur_page_q <= cur_page_n;
      pop_val_q  <= pop_val_n;
      ack_q      <= ack_n;
      page_q     <= page_n;
      value_q    <= value_n;
      seg_en_q   <= seg_en_n;
    end
  end

  assign dsp.popup_ack    = ack_q;
  assign dsp.popup_active = (state_q == POPUP);
  assign dsp.page         = page_q;
  assign dsp.value        = value_q;
  assign dsp.scan         = scan_q;
  assign dsp.seg_en       = seg_en_q;

endmodule

// File: tb/tb_score_display_scheduler.sv
// Purpose: directed self-checking bench for score_display_scheduler with TICK_DIV=4, PAGE_TICKS=3, POP_TICKS=2.
// Latency: outputs sampled 1 time unit after each rising edge; r counts cycles since the first ROTATE cycle.
// Backpressure: requester drops popup_req on the cycle it observes popup_ack.
module tb_score_display_scheduler;

  logic        clk = 1'b0;
  logic        rst, en, freeze;
  logic [20:0] combo, base_score, bonus_score, acc;
  logic [1:0]  mod;
  logic [3:0]  difficulty;
  logic [2:0]  level;

  score_display_scheduler_if dsp ();

  score_display_scheduler #(
    .TICK_DIV(4), .PAGE_TICKS(3), .POP_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .freeze(freeze),
    .combo(combo), .base_score(base_score), .bonus_score(bonus_score), .acc(acc),
    .mod(mod), .difficulty(difficulty), .level(level),
    .dsp(dsp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int r = 0;
  logic [20:0] page_val [7];

  task automatic step();
    @(posedge clk);
    #1;
    r++;
  endtask

  function automatic logic [7:0] onehot_at(input int cyc);
    return 8'(1) << ((cyc / 4) % 8);
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; freeze = 1'b0;
    dsp.popup_req = 1'b0; dsp.popup_val = '0;
    repeat (2) step();
    rst = 1'b0;
    step();
    checks++; if (dsp.page !== 3'd0) begin errors++; $display("FAIL reset_page got %0d want 0", dsp.page); end
    checks++; if (dsp.value !== 21'd0) begin errors++; $display("FAIL reset_value got %0d want 0", dsp.value); end
    checks++; if (dsp.scan !== 3'd0) begin errors++; $display("FAIL reset_scan got %0d want 0", dsp.scan); end
    checks++; if (dsp.seg_en !== 8'h00) begin errors++; $display("FAIL reset_seg_en got %h want 00", dsp.seg_en); end
    checks++; if (dsp.popup_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", dsp.popup_active); end
    dsp.popup_req = 1'b1; dsp.popup_val = 21'd7;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (dsp.popup_ack !== 1'b0) begin errors++; $display("FAIL idle_no_ack got %b want 0", dsp.popup_ack); end
      checks++; if (dsp.seg_en !== 8'h00) begin errors++; $display("FAIL idle_seg_en got %h want 00", dsp.seg_en); end
    end
    dsp.popup_req = 1'b0;
  endtask

  task automatic test_rotation_scan();
    combo = 21'd123; base_score = 21'd4567; bonus_score = 21'd89; acc = 21'd1000;
    mod = 2'd2; difficulty = 4'd9; level = 3'd5;
    page_val[0] = 21'd123; page_val[1] = 21'd4567; page_val[2] = 21'd89; page_val[3] = 21'd1000;
    page_val[4] = 21'd2;   page_val[5] = 21'd9;    page_val[6] = 21'd5;
    en = 1'b1;
    step();
    r = 0;
    for (int k = 0; k <= 84; k++) begin
      if (k > 0) step();
      checks++; if (dsp.page !== 3'((r / 12) % 7)) begin errors++; $display("FAIL rot_page r=%0d got %0d want %0d", r, dsp.page, (r / 12) % 7); end
      checks++; if (dsp.value !== page_val[(r / 12) % 7]) begin errors++; $display("FAIL rot_value r=%0d got %0d want %0d", r, dsp.value, page_val[(r / 12) % 7]); end
      checks++; if (dsp.seg_en !== onehot_at(r)) begin errors++; $display("FAIL rot_seg_en r=%0d got %h want %h", r, dsp.seg_en, onehot_at(r)); end
    end
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      checks++; if (dsp.page !== 3'd0) begin errors++; $display("FAIL freeze_page r=%0d got %0d want 0", r, dsp.page); end
      checks++; if (dsp.seg_en !== onehot_at(r)) begin errors++; $display("FAIL freeze_seg_en r=%0d got %h want %h", r, dsp.seg_en, onehot_at(r)); end
    end
    freeze = 1'b0;
    while (r < 124) begin
      step();
      checks++; if (dsp.page !== ((r >= 124) ? 3'd1 : 3'd0)) begin errors++; $display("FAIL unfreeze_page r=%0d got %0d want %0d", r, dsp.page, (r >= 124) ? 1 : 0); end
    end
  endtask

  task automatic test_popup();
    while (r < 139) step();
    checks++; if (dsp.page !== 3'd2) begin errors++; $display("FAIL pre_popup_page got %0d want 2", dsp.page); end
    dsp.popup_req = 1'b1; dsp.popup_val = 21'd999;
    while (r < 147) begin
      step();
      if (r == 140) dsp.popup_req = 1'b0;
      checks++; if (dsp.page !== 3'd7) begin errors++; $display("FAIL popup_page r=%0d got %0d want 7", r, dsp.page); end
      checks++; if (dsp.value !== 21'd999) begin errors++; $display("FAIL popup_value r=%0d got %0d want 999", r, dsp.value); end
      checks++; if (dsp.popup_active !== 1'b1) begin errors++; $display("FAIL popup_active r=%0d got %b want 1", r, dsp.popup_active); end
      checks++; if (dsp.popup_ack !== (r == 140)) begin errors++; $display("FAIL popup_ack r=%0d got %b want %b", r, dsp.popup_ack, r == 140); end
    end
    while (r < 159) begin
      step();
      checks++; if (dsp.page !== 3'd2) begin errors++; $display("FAIL resume_page r=%0d got %0d want 2", r, dsp.page); end
      checks++; if (dsp.value !== 21'd89) begin errors++; $display("FAIL resume_value r=%0d got %0d want 89", r, dsp.value); end
      checks++; if (dsp.popup_active !== 1'b0) begin errors++; $display("FAIL resume_active r=%0d got %b want 0", r, dsp.popup_active); end
    end
    step();
    checks++; if (dsp.page !== 3'd3) begin errors++; $display("FAIL resume_advance got %0d want 3", dsp.page); end
  endtask

  task automatic test_retrigger();
    dsp.popup_req = 1'b1; dsp.popup_val = 21'd111;
    while (r < 175) begin
      step();
      checks++; if (dsp.page !== 3'd7) begin errors++; $display("FAIL retrig_page r=%0d got %0d want 7", r, dsp.page); end
      checks++; if (dsp.value !== ((r < 168) ? 21'd111 : 21'd222)) begin errors++; $display("FAIL retrig_value r=%0d got %0d want %0d", r, dsp.value, (r < 168) ? 111 : 222); end
      checks++; if (dsp.popup_ack !== (r == 161 || r == 168)) begin errors++; $display("FAIL retrig_ack r=%0d got %b want %b", r, dsp.popup_ack, r == 161 || r == 168); end
      if (r == 161 || r == 168) dsp.popup_req = 1'b0;
      if (r == 167) begin dsp.popup_req = 1'b1; dsp.popup_val = 21'd222; end
    end
    step();
    checks++; if (dsp.page !== 3'd3) begin errors++; $display("FAIL retrig_return_page got %0d want 3", dsp.page); end
    checks++; if (dsp.value !== 21'd1000) begin errors++; $display("FAIL retrig_return_value got %0d want 1000", dsp.value); end
    checks++; if (dsp.popup_active !== 1'b0) begin errors++; $display("FAIL retrig_return_active got %b want 0", dsp.popup_active); end
  endtask

  task automatic test_collision();
    while (r < 199) step();
    checks++; if (dsp.page !== 3'd4) begin errors++; $display("FAIL coll_pre_page got %0d want 4", dsp.page); end
    dsp.popup_req = 1'b1; dsp.popup_val = 21'd333;
    step();
    dsp.popup_req = 1'b0;
    checks++; if (dsp.page !== 3'd7) begin errors++; $display("FAIL coll_page got %0d want 7", dsp.page); end
    checks++; if (dsp.value !== 21'd333) begin errors++; $display("FAIL coll_value got %0d want 333", dsp.value); end
    checks++; if (dsp.popup_ack !== 1'b1) begin errors++; $display("FAIL coll_ack got %b want 1", dsp.popup_ack); end
    while (r < 207) step();
    checks++; if (dsp.page !== 3'd7) begin errors++; $display("FAIL coll_hold_page got %0d want 7", dsp.page); end
    step();
    checks++; if (dsp.page !== 3'd4) begin errors++; $display("FAIL coll_restore_page got %0d want 4", dsp.page); end
    checks++; if (dsp.value !== 21'd2) begin errors++; $display("FAIL coll_restore_value got %0d want 2", dsp.value); end
  endtask

  task automatic test_abort();
    dsp.popup_req = 1'b1; dsp.popup_val = 21'd444;
    step();
    dsp.popup_req = 1'b0;
    checks++; if (dsp.popup_ack !== 1'b1) begin errors++; $display("FAIL abort_ack got %b want 1", dsp.popup_ack); end
    step();
    checks++; if (dsp.popup_active !== 1'b1) begin errors++; $display("FAIL abort_pre_active got %b want 1", dsp.popup_active); end
    step();
    en = 1'b0;
    step();
    checks++; if (dsp.page !== 3'd0) begin errors++; $display("FAIL abort_page got %0d want 0", dsp.page); end
    checks++; if (dsp.value !== 21'd0) begin errors++; $display("FAIL abort_value got %0d want 0", dsp.value); end
    checks++; if (dsp.seg_en !== 8'h00) begin errors++; $display("FAIL abort_seg_en got %h want 00", dsp.seg_en); end
    checks++; if (dsp.popup_active !== 1'b0) begin errors++; $display("FAIL abort_active got %b want 0", dsp.popup_active); end
    checks++; if (dsp.scan !== 3'd0) begin errors++; $display("FAIL abort_scan got %0d want 0", dsp.scan); end
    en = 1'b1;
    step();
    checks++; if (dsp.page !== 3'd0) begin errors++; $display("FAIL reen_page got %0d want 0", dsp.page); end
    checks++; if (dsp.value !== 21'd123) begin errors++; $display("FAIL reen_value got %0d want 123", dsp.value); end
    checks++; if (dsp.popup_active !== 1'b0) begin errors++; $display("FAIL reen_active got %b want 0", dsp.popup_active); end
    r = 0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) step();
      checks++; if (dsp.seg_en !== ((r < 4) ? 8'h01 : 8'h02)) begin errors++; $display("FAIL reen_seg_en r=%0d got %h want %h", r, dsp.seg_en, (r < 4) ? 8'h01 : 8'h02); end
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1; dsp.popup_req = 1'b1; dsp.popup_val = 21'd555;
    step();
    checks++; if (dsp.popup_ack !== 1'b0) begin errors++; $display("FAIL mrst_ack got %b want 0", dsp.popup_ack); end
    checks++; if (dsp.page !== 3'd0) begin errors++; $display("FAIL mrst_page got %0d want 0", dsp.page); end
    checks++; if (dsp.value !== 21'd0) begin errors++; $display("FAIL mrst_value got %0d want 0", dsp.value); end
    checks++; if (dsp.seg_en !== 8'h00) begin errors++; $display("FAIL mrst_seg_en got %h want 00", dsp.seg_en); end
    checks++; if (dsp.popup_active !== 1'b0) begin errors++; $display("FAIL mrst_active got %b want 0", dsp.popup_active); end
    rst = 1'b0; dsp.popup_req = 1'b0;
    step();
    checks++; if (dsp.value !== 21'd123) begin errors++; $display("FAIL mrst_resume_value got %0d want 123", dsp.value); end
    checks++; if (dsp.seg_en !== 8'h01) begin errors++; $display("FAIL mrst_resume_seg_en got %h want 01", dsp.seg_en); end
  endtask

  initial begin
    combo = '0; base_score = '0; bonus_score = '0; acc = '0;
    mod = '0; difficulty = '0; level = '0;
    test_reset();
    test_rotation_scan();
    test_freeze();
    test_popup();
    test_retrigger();
    test_collision();
    test_abort();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
